// File: rtl/instr_fetch.sv
// instr_fetch: program-memory loader and sequential instruction fetcher.
// The FSM runs IDLE -> RUN -> DONE -> IDLE. A 4'hF opcode is a HALT and is
// never issued. Optional issue counter is enabled by INSTR_FETCH_COUNT_EN;
// without it issued_cnt is tied to zero.
module instr_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic          stall,
  output logic [7:0]    instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    issued_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_instr;
  logic          r_valid;
  logic [7:0]    r_mem [DEPTH];

  logic [7:0]    w_cur;
  logic          w_halt;
  logic          w_issue;
  logic          w_accept_start;

  assign w_cur          = r_mem[r_pc];
  assign w_halt         = (w_cur[7:4] == 4'hF);
  assign w_issue        = (r_state == S_RUN) && !stall && !w_halt;
  assign w_accept_start = (r_state == S_IDLE) && start;

  // Program memory: writable only while idle; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if ((r_state == S_IDLE) && load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Fetch FSM: the write and start on one edge leave mem[0] updated before
  // the first RUN-cycle fetch, so no bypass path is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (start) begin
            r_pc    <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (stall) begin
            r_valid <= 1'b0;
          end else if (w_halt) begin
            r_valid <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_instr <= w_cur;
            r_valid <= 1'b1;
            r_pc    <= r_pc + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_FETCH_COUNT_EN
  logic [7:0] r_cnt;

  // Issue counter: cleared by an accepted start, saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h00;
    end else if (w_accept_start) begin
      r_cnt <= 8'h00;
    end else if (w_issue && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign issued_cnt = r_cnt;
`else
  logic w_unused;
  assign w_unused   = w_issue & w_accept_start;
  assign issued_cnt = 8'h00;
`endif

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a
// program-level model (expected issue list walked from the loaded memory).
module tb_instr_fetch;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef INSTR_FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = 8'h00;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [7:0]    instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [7:0]    issued_cnt;

  instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_last;
  int         m_pc;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt();
    return CNT_EN ? 32'(m_cnt) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    step();
    load_en   = 1'b0;
    m_mem[a]  = d;
  endtask

  task automatic fill(input logic [7:0] d, input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] v;
      v = d;
      if (rnd) begin
        v = 8'($urandom);
        if (v[7:4] == 4'hF) v[7:4] = 4'h3;
      end
      load(i, v);
    end
  endtask

  // Async reset in mid-cycle; everything including memory returns to zero.
  task automatic reset_mid();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_vld", 32'(instr_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(issued_cnt), 0);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_last = 8'h00; m_pc = 0; m_cnt = 0;
    stall = 1'b0; start = 1'b0; load_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start a program and follow it. Expected issue order is the memory walked
  // from 0 up to the first HALT (or max_issue entries if none). stall_pct<0
  // takes stalls from mask; noise throws load/start at the DUT while running.
  task automatic run(input int max_issue, input int stall_pct, input logic [31:0] mask,
                     input bit noise, output bit running);
    logic [7:0] q[$];
    int p, idx;
    bit halted, st;
    running = 1'b0;
    if (load_en) m_mem[int'(load_addr)] = load_data;
    start = 1'b1;
    step();
    start = 1'b0; load_en = 1'b0;
    m_pc = 0; m_cnt = 0;
    chk("start_busy", 32'(busy), 1);
    chk("start_pc", 32'(pc), 0);
    chk("start_vld", 32'(instr_valid), 0);
    chk("start_instr", 32'(instr), 32'(m_last));
    p = 0; halted = 1'b0;
    while (q.size() < max_issue) begin
      if (m_mem[p][7:4] == 4'hF) begin halted = 1'b1; break; end
      q.push_back(m_mem[p]);
      p = (p + 1) % DEPTH;
    end
    idx = 0;
    for (int cyc = 0; cyc < 4 * max_issue + 40; cyc++) begin
      st = (stall_pct < 0) ? mask[cyc % 32] : ($urandom_range(99) < stall_pct);
      stall = st;
      if (noise) begin
        load_en = 1'($urandom); load_addr = AW'($urandom);
        load_data = 8'($urandom); start = 1'($urandom);
      end
      step();
      if (st) begin
        chk("stall_vld", 32'(instr_valid), 0);
        chk("stall_instr", 32'(instr), 32'(m_last));
        chk("stall_pc", 32'(pc), 32'(m_pc));
        chk("stall_busy", 32'(busy), 1);
      end else if (idx < q.size()) begin
        m_last = q[idx]; idx++;
        m_pc = (m_pc + 1) % DEPTH;
        if (m_cnt < 255) m_cnt++;
        chk("iss_vld", 32'(instr_valid), 1);
        chk("iss_instr", 32'(instr), 32'(m_last));
        chk("iss_pc", 32'(pc), 32'(m_pc));
        chk("iss_cnt", 32'(issued_cnt), ecnt());
        chk("iss_done", 32'(done), 0);
      end else begin
        chk("halt_vld", 32'(instr_valid), 0);
        chk("halt_done", 32'(done), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_pc", 32'(pc), 32'(m_pc));
        chk("halt_instr", 32'(instr), 32'(m_last));
        chk("halt_cnt", 32'(issued_cnt), ecnt());
        stall = 1'b0;
        step();
        load_en = 1'b0; start = 1'b0;
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_vld", 32'(instr_valid), 0);
        return;
      end
      if (!halted && idx == max_issue) begin
        stall = 1'b0; load_en = 1'b0; start = 1'b0;
        running = 1'b1;
        return;
      end
    end
    n_chk++; n_err++;
    $error("FAIL run_timeout: observed %0d issues expected %0d", idx, q.size());
    stall = 1'b0; load_en = 1'b0; start = 1'b0;
  endtask

  initial begin
    bit running;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_last = 8'h00; m_pc = 0; m_cnt = 0;

    #12;
    chk("por_busy", 32'(busy), 0);
    chk("por_pc", 32'(pc), 0);
    chk("por_instr", 32'(instr), 0);
    chk("por_vld", 32'(instr_valid), 0);
    chk("por_done", 32'(done), 0);
    chk("por_cnt", 32'(issued_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_hold", 32'(busy), 0);

    // Basic three-entry program, then the same with a 3-cycle stall.
    load(0, 8'h10); load(1, 8'h20); load(2, 8'hF0);
    run(100, 0, 32'h0, 1'b0, running);
    run(100, -1, 32'hE, 1'b0, running);

    // Random programs with random stalls and ignored load/start traffic.
    repeat (6) begin
      fill(8'h00, 1'b1);
      load($urandom_range(DEPTH - 1), 8'hF5);
      run(60, 30, 32'h0, 1'b1, running);
      if (running) reset_mid();
    end

    // No HALT: pc wraps, 20 back-to-back issues, then reset at pc=5.
    fill(8'h11, 1'b0);
    run(20, 0, 32'h0, 1'b0, running);
    chk("wrap_running", 32'(running), 1);
    chk("wrap_cnt", 32'(issued_cnt), ecnt());
    step();
    m_last = 8'h11; m_pc = 5; m_cnt++;
    chk("pc5_vld", 32'(instr_valid), 1);
    chk("pc5_pc", 32'(pc), 5);
    reset_mid();
    run(3, 0, 32'h0, 1'b0, running);
    reset_mid();

    // Long random run to reach counter saturation.
    fill(8'h00, 1'b1);
    run(300, 20, 32'h0, 1'b1, running);
    reset_mid();

    // Loads during RUN are dropped; load with start in IDLE is seen at once.
    load(0, 8'h10); load(1, 8'h20); load(2, 8'hF0);
    run(100, 25, 32'h0, 1'b1, running);
    load_en = 1'b1; load_addr = '0; load_data = 8'hAA;
    run(100, 0, 32'h0, 1'b0, running);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 8-bit program-memory entries (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default 4, meaning the address width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load_en  input  1  program-memory write strobe.
REQ-006 The block SHALL have port load_addr  input  AW  program-memory write address.
REQ-007 The block SHALL have port load_data  input  8  program-memory write data.
REQ-008 The block SHALL have port start  input  1  begin execution from address 0.
REQ-009 The block SHALL have port stall  input  1  downstream not ready; hold the fetch.
REQ-010 The block SHALL have port instr  output  8  instruction to the processor (opcode in [7:4]).
REQ-011 The block SHALL have port instr_valid  output  1  instr is a newly issued instruction this cycle.
REQ-012 The block SHALL have port pc  output  AW  address of the next entry to fetch.
REQ-013 The block SHALL have port busy  output  1  high in RUN state.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse on program completion.
REQ-015 The block SHALL have port issued_cnt  output  8  count of instructions issued since the last start.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-017 In IDLE, load_en=1 SHALL write load_data to mem[load_addr] at the clock edge; load_en SHALL be ignored in RUN and DONE.
REQ-018 start=1 in IDLE SHALL set pc=0 and move to RUN; start SHALL be ignored in RUN and DONE.
REQ-019 When load_en and start are both high in IDLE, the block SHALL perform the write and the start on the same edge, and the first fetch SHALL see the written data.
REQ-020 In RUN with stall=0 and mem[pc][7:4]!=4'b1111, the block SHALL register instr<=mem[pc], assert instr_valid=1 and set pc<=pc+1, giving 1-cycle latency from the fetch edge to the output.
REQ-021 In RUN with stall=1, the block SHALL hold instr and pc, drive instr_valid=0 and stay in RUN.
REQ-022 In RUN with stall=0 and mem[pc][7:4]==4'b1111 (HALT), the block SHALL NOT issue the HALT entry, SHALL drive instr_valid=0, SHALL hold pc and SHALL move to DONE.
REQ-023 The block SHALL wrap pc from DEPTH-1 to 0 with no other effect.
REQ-024 DONE SHALL last exactly one cycle with done=1, then the block SHALL return to IDLE; done SHALL be 0 in all other cycles.
REQ-025 busy SHALL equal 1 exactly while the state is RUN.
REQ-026 instr SHALL hold its last value whenever instr_valid=0.
REQ-027 issued_cnt SHALL clear to 0 on an accepted start, increment by 1 with each instr_valid=1 cycle, and saturate at 255.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, instr=8'h00, instr_valid=0, done=0, busy=0, issued_cnt=0 and all mem entries to 8'h00, regardless of the operation in progress.
REQ-029 Deassertion of rst_n SHALL take effect synchronously, with the first state change on the following rising clk edge.

Configuration
REQ-030 With macro INSTR_FETCH_COUNT_EN defined, the block SHALL implement issued_cnt as specified in REQ-027.
REQ-031 Without INSTR_FETCH_COUNT_EN, the issued_cnt port SHALL still exist, SHALL be tied to 8'h00, and the block SHALL contain no counter logic.

Verification
REQ-032 The bench SHALL cover this case: load mem[0..2]=8'h10,8'h20,8'hF0, then pulse start -> instr 8'h10 then 8'h20 on consecutive cycles with instr_valid=1, then done=1 for one cycle, busy=0, issued_cnt=2.
REQ-033 The bench SHALL cover this case: same program with stall=1 for 3 cycles after the first issue -> instr holds 8'h10, instr_valid=0 for 3 cycles, pc=1, then 8'h20 issues.
REQ-034 The bench SHALL cover this case: DEPTH=16, no HALT loaded (all 8'h11), run 20 cycles -> pc wraps 15->0, instr_valid stays 1, issued_cnt=20.
REQ-035 The bench SHALL cover this case: rst_n=0 mid-RUN (pc=5) -> immediately busy=0, pc=0, instr=8'h00, mem[0] reads 8'h00 on the next run, which immediately issues 8'h00.
REQ-036 The bench SHALL cover this case: load_en with load_addr=0, load_data=8'hAA during RUN -> mem unchanged; in IDLE, load_en with start on the same edge -> the first issued instr is 8'hAA.
REQ-037 The bench SHALL cover this case: build without INSTR_FETCH_COUNT_EN and rerun REQ-032 -> issued_cnt=0 throughout.
